// File: rtl/bcd_gray_rr_sched.sv
// Round-robin scheduler sharing one BCD-to-Gray stage among N_REQ requesters.
// The result is registered with its source tag, an invalid-digit flag and a saturating error count.
module bcd_gray_rr_sched #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_digit,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_gray,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_err,
  output logic [ERR_W-1:0]   err_cnt,
  input  logic               err_clr
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state, state_next;
  logic [SRC_W-1:0]   ptr;
  logic               can_accept;
  logic               transfer;
  logic [N_REQ-1:0]   grant;
  logic [SRC_W-1:0]   grant_idx;
  logic [3:0]         digit;
  logic               bad;
  logic [ERR_W-1:0]   err_base, err_next;
  int unsigned        idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // rst_n gates acceptance so req_ready stays low for the whole reset window
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    transfer   = 1'b0;
    idx        = 0;
    can_accept = rst_n && ((state == EMPTY) || out_ready);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (j == idx && req_valid[j] && can_accept && !transfer) begin
          grant[j]  = 1'b1;
          grant_idx = SRC_W'(j);
          transfer  = 1'b1;
        end
      end
    end

    state_next = state;
    if (transfer)                      state_next = FULL;
    else if (state == FULL && out_ready) state_next = EMPTY;
  end

  always_comb begin
    digit = '0;
    for (int unsigned k = 0; k < N_REQ; k++)
      if (grant[k]) digit = req_digit[4*k +: 4];
  end

  assign bad       = digit > 4'd9;
  assign req_ready = grant;
  assign out_valid = (state == FULL);

  // clear applies before the increment so a same-cycle bad digit leaves a count of 1
  always_comb begin
    err_base = err_clr ? '0 : err_cnt;
    err_next = err_base;
    if (transfer && bad && (err_base != '1)) err_next = err_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_gray <= '0;
      out_src  <= '0;
      out_err  <= 1'b0;
      err_cnt  <= '0;
      ptr      <= '0;
    end else begin
      err_cnt <= err_next;
      if (transfer) begin
        out_gray <= digit ^ (digit >> 1);
        out_src  <= grant_idx;
        out_err  <= bad;
        ptr      <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_gray_rr_sched.sv
// Directed self-checking bench for bcd_gray_rr_sched with hand-computed expectations.
module tb_bcd_gray_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_digit;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_gray;
  logic [1:0]  out_src;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [3:0] gray_exp [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

  bcd_gray_rr_sched #(.N_REQ(4), .SRC_W(2), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_digit (req_digit),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_src   (out_src),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_digit = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    #3;
    check("rst_ready", req_ready, 4'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_gray", out_gray, 4'h0);
    check("rst_src", out_src, 2'd0);
    check("rst_err", out_err, 1'b0);
    check("rst_cnt", err_cnt, 8'd0);
    do_reset();

    // single requester 0, digits 0..9
    for (int i = 0; i < 10; i++) begin
      req_valid = 4'b0001;
      req_digit[3:0] = 4'(i);
      #1 check("t1_ready", req_ready, 4'b0001);
      step();
      check("t1_valid", out_valid, 1'b1);
      check("t1_gray", out_gray, gray_exp[i]);
      check("t1_err", out_err, 1'b0);
      check("t1_src", out_src, 2'd0);
    end
    req_valid = '0;
    step();
    check("t1_drain", out_valid, 1'b0);
    check("t1_gray_hold", out_gray, 4'hD);
    check("t1_cnt", err_cnt, 8'd0);

    // all four requesters continuously valid
    do_reset();
    req_digit = 16'h3210;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 check("t2_ready", req_ready, 4'b0001 << (k % 4));
      step();
      check("t2_valid", out_valid, 1'b1);
      check("t2_src", out_src, 32'(k % 4));
      check("t2_gray", out_gray, gray_exp[k % 4]);
    end
    req_valid = '0;
    step();

    // requesters 1 and 3 with back-pressure
    req_digit = 16'h8050;
    req_valid = 4'b1010;
    #1 check("t3_ready0", req_ready, 4'b0010);
    step();
    check("t3_src0", out_src, 2'd1);
    check("t3_gray0", out_gray, 4'h7);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check("t3_bp_ready", req_ready, 4'h0);
      step();
      check("t3_bp_valid", out_valid, 1'b1);
      check("t3_bp_src", out_src, 2'd1);
      check("t3_bp_gray", out_gray, 4'h7);
      check("t3_bp_cnt", err_cnt, 8'd0);
    end
    out_ready = 1'b1;
    #1 check("t3_rel_ready", req_ready, 4'b1000);
    step();
    check("t3_rel_src", out_src, 2'd3);
    check("t3_rel_gray", out_gray, 4'hC);
    check("t3_rel_err", out_err, 1'b0);
    #1 check("t3_next_ready", req_ready, 4'b0010);
    req_valid = '0;
    step();
    check("t3_empty", out_valid, 1'b0);

    // invalid digit 12 on requester 2, then saturation
    req_digit = 16'h0C00;
    req_valid = 4'b0100;
    #1 check("t4_ready", req_ready, 4'b0100);
    step();
    check("t4_gray", out_gray, 4'hA);
    check("t4_err", out_err, 1'b1);
    check("t4_cnt", err_cnt, 8'd1);
    check("t4_src", out_src, 2'd2);
    req_digit = 16'h0F00;
    for (int k = 0; k < 254; k++) step();
    check("t4_cnt_max", err_cnt, 8'd255);
    step();
    check("t4_cnt_sat", err_cnt, 8'd255);
    check("t4_gray15", out_gray, 4'h8);
    req_valid = '0;

    // clear-then-count in the same cycle
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_clr", err_cnt, 8'd0);
    req_valid = 4'b0100;
    for (int k = 0; k < 7; k++) step();
    check("t5_cnt7", err_cnt, 8'd7);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_clr_cnt", err_cnt, 8'd1);
    check("t5_clr_gray", out_gray, 4'h8);
    req_valid = '0;
    step();

    // reset while a result is held and requests are pending
    req_digit = 16'h4300;
    req_valid = 4'b1100;
    #1 check("t6_ready", req_ready, 4'b1000);
    step();
    check("t6_valid", out_valid, 1'b1);
    check("t6_src", out_src, 2'd3);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_ready", req_ready, 4'h0);
    check("t6_rst_src", out_src, 2'd0);
    check("t6_rst_cnt", err_cnt, 8'd0);
    step();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("t6_first_ready", req_ready, 4'b0100);
    step();
    check("t6_first_src", out_src, 2'd2);
    check("t6_first_gray", out_gray, 4'h2);
    req_valid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_gray_rr_sched.md
Name: bcd_gray_rr_sched

Overview:
Round-robin scheduler that shares one 4-bit BCD-to-Gray conversion stage among N_REQ requesters over valid/ready handshakes. Each cycle it grants at most one requester and converts that requester's digit. The result is registered with a source tag and an invalid-digit flag. It sits between the digit producers (display/encoder front-ends) and the single downstream Gray-code consumer.

Parameters:
N_REQ, 4, number of requesters (2..16)
SRC_W, 2, width of source tag; must satisfy 2**SRC_W >= N_REQ
ERR_W, 8, width of the saturating invalid-digit counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester digit valid
req_digit  input  4*N_REQ  requester i digit at bits [4i+3:4i]; bit 3 = MSB
req_ready  output  N_REQ  one-hot grant/accept, combinational
out_valid  output  1  registered result valid
out_ready  input  1  downstream accepts result
out_gray  output  4  Gray code of granted digit
out_src  output  SRC_W  index of requester that produced out_gray
out_err  output  1  granted digit was > 9
err_cnt  output  ERR_W  saturating count of accepted digits > 9
err_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Reset (async assert, sync-style deassert use): out_valid=0, out_gray=0, out_src=0, out_err=0, err_cnt=0, rr pointer=0. req_ready=0 while rst_n=0.
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = EMPTY or (FULL and out_ready).
- Grant rule: when can_accept=1 and any req_valid=1, assert req_ready for exactly one requester, the first with valid=1 searching from the rr pointer upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...). Otherwise req_ready is all zero.
- req_ready depends combinationally on req_valid, out_ready and state. Requesters must not make req_valid depend on req_ready.
- Transfer: occurs when req_valid[i] and req_ready[i] are both 1. On the next edge:
  - out_gray is loaded with gray[3]=d[3], gray[2]=d[3]^d[2], gray[1]=d[2]^d[1], gray[0]=d[1]^d[0].
  - out_src is loaded with i.
  - out_err is loaded with (d > 9).
  - out_valid is set to 1.
  - The rr pointer becomes (i+1) mod N_REQ.
- Latency: 1 cycle from transfer to out_valid. Throughput: 1 digit/cycle when out_ready is held high.
- FULL and out_ready=1 with no transfer: the register goes EMPTY (out_valid=0) and the data fields hold their values.
- FULL and out_ready=0: all outputs hold and req_ready=0 (back-pressure).
- Rr pointer is unchanged on cycles without a transfer.
- Digits 10..15 are still converted and passed downstream; only out_err marks them.
- err_cnt:
  - Increments by 1 on each transfer with d > 9 and saturates at 2**ERR_W-1.
  - err_clr=1 sets err_cnt to 0. If a d>9 transfer occurs in the same cycle, err_cnt becomes 1 (clear first, then count).
- An unstable req_digit while req_valid=1 and not yet granted is legal; the value sampled on the transfer edge is used.
- Reset asserted mid-operation: a pending result is discarded, outputs return to reset values immediately, and the pointer returns to 0.

Test Plan:
- Single requester 0, digits 0..9 in sequence, out_ready=1 -> out_gray = 0,1,3,2,6,7,5,4,C,D, each one cycle after its transfer; out_err=0; err_cnt=0.
- All four requesters valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1,...; one transfer per cycle; no requester starved.
- Requesters 1 and 3 valid, out_ready held 0 for 5 cycles after the first result -> out_valid stays 1; out_src, out_gray and err_cnt are stable; req_ready=0. On release, the next grant goes to the requester after the last granted one.
- Requester 2 sends digit 12 (0xC) -> out_gray=0xA, out_err=1, err_cnt=1. Holding err_cnt at 255 and sending another invalid digit -> err_cnt stays 255.
- err_clr=1 in the same cycle as a digit-15 transfer with err_cnt=7 -> err_cnt=1 next cycle and out_gray=0x8.
- rst_n pulsed low while out_valid=1 and requests are pending -> out_valid=0 and req_ready=0 immediately. After release, the first grant goes to the lowest-indexed valid requester.
